// File: rtl/umem_pkg.sv
// Shared types and default widths for the unified memory responder.
package umem_pkg;

  localparam int UMEM_ADDR_WIDTH = 8;
  localparam int UMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

endpackage

// File: rtl/umem_array.sv
// Single-port synchronous RAM with registered, enable-gated read output.
module umem_array
  import umem_pkg::*;
#(
  parameter int ADDR_WIDTH = UMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = UMEM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_reg [2**ADDR_WIDTH];

  // Storage is never cleared; only the output register honours reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[index] <= wdata;
    end
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_reg[index];
    end
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder: one request at a time, fixed wait latency.
// Optional macro UMEM_ERR_CHECK_EN rejects misaligned and out-of-range addresses.
module unified_mem_responder
  import umem_pkg::*;
#(
  parameter int ADDR_WIDTH = UMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = UMEM_DATA_WIDTH,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_error
);

  state_t                state_reg, state_next;
  logic [3:0]            count_reg, count_next;
  op_t                   op_reg, op_next;
  logic [ADDR_WIDTH-1:0] index_reg, index_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  err_reg, err_next;
  logic                  mem_ready_reg, mem_busy_reg, mem_error_reg;
  logic                  req_err;
  logic                  array_we, array_re;
  logic [ADDR_WIDTH-1:0] array_index;

  always_comb begin
    req_err = MemRead && MemWrite;
`ifdef UMEM_ERR_CHECK_EN
    if (address[1:0] != 2'b00 || address[31:ADDR_WIDTH+2] != '0) begin
      req_err = 1'b1;
    end
`endif
  end

`ifndef UMEM_ERR_CHECK_EN
  // Without checking, the byte offset and upper bits are simply truncated away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    index_next = index_reg;
    wdata_next = wdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (MemRead || MemWrite) begin
          op_next    = MemWrite ? OP_WR : OP_RD;
          index_next = address[ADDR_WIDTH+1:2];
          wdata_next = write_data;
          err_next   = req_err;
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg <= 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      op_reg        <= OP_RD;
      index_reg     <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      mem_ready_reg <= 1'b0;
      mem_busy_reg  <= 1'b0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      op_reg        <= op_next;
      index_reg     <= index_next;
      wdata_reg     <= wdata_next;
      err_reg       <= err_next;
      mem_ready_reg <= (state_next == RESP);
      mem_busy_reg  <= (state_next != IDLE);
      mem_error_reg <= (state_next == RESP) && err_next;
    end
  end

  // The read is launched on the edge entering RESP so read_data lines up with mem_ready;
  // the write commits on the edge leaving RESP. Reset gates both so an abandoned request never lands.
  assign array_we    = (state_reg == RESP) && (op_reg == OP_WR) && !err_reg && !reset;
  assign array_re    = (state_next == RESP) && (op_next == OP_RD) && !err_next && !reset;
  assign array_index = (state_reg == RESP) ? index_reg : index_next;

  umem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (array_we),
    .re    (array_re),
    .index (array_index),
    .wdata (wdata_reg),
    .rdata (read_data)
  );

  assign mem_ready = mem_ready_reg;
  assign mem_busy  = mem_busy_reg;
  assign mem_error = mem_error_reg;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: LATENCY=2 responder plus a LATENCY=0 instance, against a word-array model.
module tb_unified_mem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        mem_ready, mem_busy, mem_error;

  logic        r0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, wd0 = '0;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [256];
  bit          mem_valid [256];
  logic [31:0] rd_model = '0;
  bit          rd_known = 1'b1;

  always #5 clock = ~clock;

  unified_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .read_data(read_data),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_error(mem_error)
  );

  unified_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .MemRead(r0), .MemWrite(w0),
    .address(a0), .write_data(wd0), .read_data(rdata0),
    .mem_ready(ready0), .mem_busy(busy0), .mem_error(err0)
  );

  // Issue one request from an IDLE cycle, check every cycle through completion and the idle cycle after.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input string name);
    logic [7:0]  idx;
    logic        err;
    logic [31:0] prev_rd;
    bit          prev_known;
    idx = addr[9:2];
    err = rd && wr;
`ifdef UMEM_ERR_CHECK_EN
    if (addr[1:0] != 2'b00 || addr[31:10] != 22'd0) err = 1'b1;
`endif
    prev_rd    = rd_model;
    prev_known = rd_known;
    MemRead = rd; MemWrite = wr; address = addr; write_data = wd;
    @(posedge clock); #1;
    MemRead = 1'b0; MemWrite = 1'b0; address = $urandom; write_data = $urandom;
    if (!err && wr) begin
      mem_model[idx] = wd;
      mem_valid[idx] = 1'b1;
    end
    if (!err && rd) begin
      if (mem_valid[idx]) begin
        rd_model = mem_model[idx];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) begin
        @(posedge clock); #1;
      end
      checks++;
      if (mem_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy k=%0d got=%b want=1", name, k, mem_busy);
      end
      checks++;
      if (mem_ready !== (k == LAT + 1)) begin
        errors++;
        $display("FAIL %s ready k=%0d got=%b want=%0d", name, k, mem_ready, (k == LAT + 1));
      end
      checks++;
      if (mem_error !== ((k == LAT + 1) && err)) begin
        errors++;
        $display("FAIL %s error k=%0d got=%b want=%0d", name, k, mem_error, ((k == LAT + 1) && err));
      end
      if (k < LAT + 1 && prev_known) begin
        checks++;
        if (read_data !== prev_rd) begin
          errors++;
          $display("FAIL %s rdata_hold k=%0d got=%h want=%h", name, k, read_data, prev_rd);
        end
      end
    end
    if (rd_known) begin
      checks++;
      if (read_data !== rd_model) begin
        errors++;
        $display("FAIL %s read_data got=%h want=%h", name, read_data, rd_model);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (mem_busy !== 1'b0 || mem_ready !== 1'b0 || mem_error !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got busy=%b ready=%b err=%b want 000", name, mem_busy, mem_ready, mem_error);
    end
    $display("txn %-10s rd=%b wr=%b addr=%h wd=%h err=%b read_data=%h", name, rd, wr, addr, wd, err, read_data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (read_data !== 32'd0 || mem_ready !== 1'b0 || mem_busy !== 1'b0 || mem_error !== 1'b0) begin
      errors++;
      $display("FAIL reset got rd=%h ready=%b busy=%b err=%b want 0", read_data, mem_ready, mem_busy, mem_error);
    end
    reset = 1'b0;
    rd_model = '0;
    rd_known = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
    issue(1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 32'h4, 32'h11111111, "b2b_wr4");
    issue(1'b1, 1'b0, 32'h4, 32'h0, "b2b_rd4");
    issue(1'b0, 1'b1, 32'h8, 32'h22222222, "b2b_wr8");
    issue(1'b1, 1'b0, 32'h4, 32'h0, "b2b_rd4b");
  endtask

  task automatic test_both_strobes();
    issue(1'b0, 1'b1, 32'h20, 32'h5A5A1234, "pre_wr20");
    issue(1'b1, 1'b0, 32'h10, 32'h0, "pre_rd10");
    issue(1'b1, 1'b1, 32'h20, 32'hFFFF0000, "both_20");
    issue(1'b1, 1'b0, 32'h20, 32'h0, "post_rd20");
  endtask

  task automatic test_addr_check();
    issue(1'b0, 1'b1, 32'h4, 32'h0000AAAA, "pre_wr4");
    issue(1'b0, 1'b1, 32'h6, 32'h0000BBBB, "wr_misal");
    issue(1'b0, 1'b1, 32'h400, 32'h0000CCCC, "wr_range");
    issue(1'b1, 1'b0, 32'h4, 32'h0, "rd_4");
    issue(1'b1, 1'b0, 32'h0, 32'h0, "rd_0");
  endtask

  task automatic test_reset_abort();
    issue(1'b0, 1'b1, 32'h30, 32'h0BADC0DE, "pre_wr30");
    MemWrite = 1'b1; address = 32'h30; write_data = 32'hCAFEF00D;
    @(posedge clock); #1;
    MemWrite = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rd_model = '0;
    rd_known = 1'b1;
    checks++;
    if (read_data !== 32'd0 || mem_ready !== 1'b0 || mem_busy !== 1'b0 || mem_error !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got rd=%h ready=%b busy=%b err=%b want 0", read_data, mem_ready, mem_busy, mem_error);
    end
    @(posedge clock); #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_noready got=%b want=0", mem_ready);
    end
    $display("txn abort      write CAFEF00D @30 abandoned by reset");
    issue(1'b1, 1'b0, 32'h30, 32'h0, "rd_30");
  endtask

  task automatic test_random();
    int          r;
    logic [7:0]  idx;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      idx  = 8'($urandom_range(0, 15));
      addr = {24'd0, idx} << 2;
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC03);
      if (r < 4 || (r < 8 && !mem_valid[addr[9:2]])) begin
        issue(1'b0, 1'b1, addr, $urandom, "rnd_wr");
      end else if (r < 8) begin
        issue(1'b1, 1'b0, addr, $urandom, "rnd_rd");
      end else begin
        issue(1'b1, 1'b1, addr, $urandom, "rnd_both");
      end
    end
  endtask

  task automatic test_latency0();
    logic [31:0] v;
    v = $urandom;
    w0 = 1'b1; a0 = 32'h40; wd0 = v;
    @(posedge clock); #1;
    w0 = 1'b0;
    checks++;
    if (ready0 !== 1'b1 || busy0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL lat0_wr got ready=%b busy=%b err=%b want 110", ready0, busy0, err0);
    end
    @(posedge clock); #1;
    $display("txn lat0_wr    addr=00000040 wd=%h", v);
    for (int i = 0; i < 3; i++) begin
      r0 = 1'b1; a0 = 32'h40;
      @(posedge clock); #1;
      r0 = 1'b0;
      checks++;
      if (ready0 !== 1'b1 || rdata0 !== v) begin
        errors++;
        $display("FAIL lat0_rd%0d got ready=%b rdata=%h want ready=1 rdata=%h", i, ready0, rdata0, v);
      end
      @(posedge clock); #1;
      checks++;
      if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL lat0_idle%0d got ready=%b busy=%b want 00", i, ready0, busy0);
      end
      $display("txn lat0_rd%0d   addr=00000040 read_data=%h", i, rdata0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_valid[i] = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_strobes();
    test_addr_check();
    test_reset_abort();
    test_random();
    test_latency0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
